// File: rtl/blitter_mem_arbiter.sv
// blitter_mem_arbiter: shares one memory master port between the CPU (priority) and the blitter FIFO (bounded bursts, starvation override).
// Optional `ARB_STATS_EN adds stat_clear / stat_blit_beats / stat_cpu_wait.
module blitter_mem_arbiter #(
  parameter int BURST_LEN    = 16,
  parameter int STARVE_LIMIT = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_valid,
  input  logic        cpu_write,
  input  logic [25:0] cpu_address,
  input  logic [3:0]  cpu_byte_en,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic [25:0] blit_address,
  input  logic [3:0]  blit_byte_en,
  input  logic [31:0] blit_data,
  input  logic        blit_valid,
  output logic        blit_ready,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [25:0] mem_address,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  arb_owner
`ifdef ARB_STATS_EN
  ,
  input  logic        stat_clear,
  output logic [31:0] stat_blit_beats,
  output logic [31:0] stat_cpu_wait
`endif
);
  typedef enum logic [1:0] {IDLE, CPU_REQ, CPU_RD, BLIT} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_beat_cnt, r_starve_cnt;
  logic        r_rd_done;
  logic [31:0] r_cpu_rdata;
  logic        w_cpu_req, w_cpu_acc, w_blit_xfer, w_burst_end, w_starved;
  // A read's request is complete in the cycle its cpu_ready pulses, so it must not be re-granted then.
  assign w_cpu_req   = cpu_valid && !r_rd_done;
  assign w_cpu_acc   = r_state == CPU_REQ && cpu_valid && mem_ready;
  assign w_blit_xfer = r_state == BLIT && blit_valid && mem_ready;
  assign w_burst_end = r_beat_cnt + 8'd1 == 8'(BURST_LEN);
  assign w_starved   = blit_valid && r_starve_cnt >= 8'(STARVE_LIMIT);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_starved ? BLIT : w_cpu_req ? CPU_REQ : blit_valid ? BLIT : IDLE;
      CPU_REQ: w_next = !cpu_valid ? IDLE : !mem_ready ? CPU_REQ : cpu_write ? IDLE : CPU_RD;
      CPU_RD:  w_next = mem_rvalid ? IDLE : CPU_RD;
      default: w_next = (!blit_valid || (mem_ready && w_burst_end)) ? IDLE : BLIT;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_beat_cnt   <= '0;
      r_starve_cnt <= '0;
      r_rd_done    <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      r_state    <= w_next;
      r_rd_done  <= r_state == CPU_RD && mem_rvalid;
      if (r_state == CPU_RD && mem_rvalid)
        r_cpu_rdata <= mem_rdata;
      r_beat_cnt <= r_state != BLIT ? 8'd0 : r_beat_cnt + 8'(w_blit_xfer);
      r_starve_cnt <= (r_state != BLIT && w_next == BLIT) ? 8'd0 :
                      (blit_valid && r_state != BLIT && r_starve_cnt != 8'hFF) ? r_starve_cnt + 8'd1 : r_starve_cnt;
    end
  end
  assign mem_valid   = (r_state == CPU_REQ && cpu_valid) || (r_state == BLIT && blit_valid);
  assign mem_write   = r_state == BLIT || (r_state == CPU_REQ && cpu_write);
  assign mem_address = r_state == BLIT ? blit_address : r_state == CPU_REQ ? cpu_address : '0;
  assign mem_byte_en = r_state == BLIT ? blit_byte_en : r_state == CPU_REQ ? cpu_byte_en : '0;
  assign mem_wdata   = r_state == BLIT ? blit_data : r_state == CPU_REQ ? cpu_wdata : '0;
  assign blit_ready  = r_state == BLIT && mem_ready;
  assign cpu_ready   = (w_cpu_acc && cpu_write) || r_rd_done;
  assign cpu_rdata   = r_cpu_rdata;
  assign arb_owner   = r_state == BLIT ? 2'd2 : r_state == IDLE ? 2'd0 : 2'd1;
`ifdef ARB_STATS_EN
  logic [31:0] r_stat_blit, r_stat_wait;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_blit <= '0;
      r_stat_wait <= '0;
    end else if (stat_clear) begin
      r_stat_blit <= '0;
      r_stat_wait <= '0;
    end else begin
      r_stat_blit <= r_stat_blit + 32'(w_blit_xfer);
      r_stat_wait <= r_stat_wait + 32'(cpu_valid && r_state != CPU_REQ && r_state != CPU_RD);
    end
  end
  assign stat_blit_beats = r_stat_blit;
  assign stat_cpu_wait   = r_stat_wait;
`endif
endmodule

// File: tb/tb_blitter_mem_arbiter.sv
// tb_blitter_mem_arbiter: randomized + directed scoreboard bench for blitter_mem_arbiter.
// Stimulus pushes expected writes/replies into queues; a negedge monitor pops and compares.
module tb_blitter_mem_arbiter;
  localparam int BL = 16;
  localparam int SL = 32;
  localparam logic [25:0] RD_A = 26'h0000456;

  logic clock = 1'b0, reset_n = 1'b1;
  logic cpu_valid = 0, cpu_write = 0, cpu_ready;
  logic [25:0] cpu_address = '0, blit_address = '0, mem_address;
  logic [3:0] cpu_byte_en = '0, blit_byte_en = '0, mem_byte_en;
  logic [31:0] cpu_wdata = '0, blit_data = '0, cpu_rdata, mem_wdata, mem_rdata = '0;
  logic blit_valid = 0, blit_ready, mem_valid, mem_write, mem_ready = 0, mem_rvalid = 0;
  logic [1:0] arb_owner;
  logic stat_clr = 0;
`ifdef ARB_STATS_EN
  logic [31:0] stat_blit_beats, stat_cpu_wait;
`endif

  always #5 clock = ~clock;

  blitter_mem_arbiter #(.BURST_LEN(BL), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_byte_en(cpu_byte_en), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .blit_address(blit_address), .blit_byte_en(blit_byte_en), .blit_data(blit_data),
    .blit_valid(blit_valid), .blit_ready(blit_ready),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_address(mem_address),
    .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .arb_owner(arb_owner)
`ifdef ARB_STATS_EN
    , .stat_clear(stat_clr), .stat_blit_beats(stat_blit_beats), .stat_cpu_wait(stat_cpu_wait)
`endif
  );

  typedef struct packed {logic [25:0] a; logic [3:0] be; logic [31:0] d;} wr_t;
  typedef struct packed {logic wr; logic [25:0] a; logic [3:0] be; logic [31:0] d; logic [31:0] rd;} cpu_t;
  wr_t bq[$], exp_bw[$];
  cpu_t cq[$], exp_c[$];
  int bursts[$];
  int vecs = 0, miss = 0, cyc = 0;
  int p_cpu = 0, p_blit = 0, p_rd = 50, p_rdy = 100;
  bit toggle_rdy = 0;
  bit s_bx = 0, s_cdone = 0, s_racc = 0;
  logic [25:0] s_raddr = '0, rd_addr = '0;
  int rd_cnt = 0;
  int w_model = 0, run_beats = 0, prev_owner = 0, pred = -1, m_own = 0, n_bx = 0, n_cw = 0;
  bit prev_rvalid = 0, prev_bv = 0, rd_out = 0;
  cpu_t m_c;
  wr_t m_w;

  function automatic logic [31:0] rd_val(input logic [25:0] a);
    return a == RD_A ? 32'hCAFEF00D : 32'({6'd0, a}) * 32'h9E3779B1;
  endfunction

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask

  task automatic push_blit();
    wr_t w;
    w.a = {1'b1, 25'($urandom)};
    w.be = 4'($urandom);
    w.d = $urandom;
    bq.push_back(w);
    exp_bw.push_back(w);
  endtask

  task automatic issue(input cpu_t c);
    c.rd = rd_val(c.a);
    cpu_valid = 1; cpu_write = c.wr; cpu_address = c.a; cpu_byte_en = c.be; cpu_wdata = c.d;
    exp_c.push_back(c);
  endtask

  // one clock: apply handshakes seen by the monitor, run the memory model, issue new stimulus
  task automatic step();
    cpu_t c;
    @(posedge clock); #1; cyc++;
    if (s_bx && bq.size() != 0) void'(bq.pop_front());
    if (s_cdone) cpu_valid = 0;
    mem_rvalid = 0;
    if (rd_cnt != 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin mem_rvalid = 1; mem_rdata = rd_val(rd_addr); end
    end
    if (s_racc) begin rd_cnt = 3; rd_addr = s_raddr; end
    if (int'($urandom_range(99)) < p_blit) push_blit();
    if (!cpu_valid) begin
      if (cq.size() != 0) issue(cq.pop_front());
      else if (int'($urandom_range(99)) < p_cpu) begin
        c.wr = int'($urandom_range(99)) >= p_rd;
        c.a = {1'b0, 25'($urandom)}; c.be = 4'($urandom); c.d = $urandom; c.rd = '0;
        issue(c);
      end
    end
    blit_valid = bq.size() != 0;
    if (bq.size() != 0) {blit_address, blit_byte_en, blit_data} = bq[0];
    mem_ready = toggle_rdy ? ~mem_ready : int'($urandom_range(99)) < p_rdy;
  endtask

  task automatic drain(input int bound, input string n);
    int k = 0;
    while ((bq.size() != 0 || exp_bw.size() != 0 || exp_c.size() != 0 || cq.size() != 0) && k < bound) begin
      step(); k++;
    end
    chk({n, "_drained"}, 64'(k < bound), 64'(1));
    repeat (3) step();
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_mem_valid"}, 64'(mem_valid), 64'(0));
    chk({n, "_cpu_ready"}, 64'(cpu_ready), 64'(0));
    chk({n, "_blit_ready"}, 64'(blit_ready), 64'(0));
    chk({n, "_owner"}, 64'(arb_owner), 64'(0));
    chk({n, "_cpu_rdata"}, 64'(cpu_rdata), 64'(0));
  endtask

  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_model = 0; run_beats = 0; prev_owner = 0; pred = -1; prev_rvalid = 0; prev_bv = 0;
      rd_out = 0; s_bx = 0; s_cdone = 0; s_racc = 0; n_bx = 0; n_cw = 0;
    end else begin
      m_own = int'(arb_owner);
      s_bx = blit_valid && blit_ready;
      s_cdone = 0; s_racc = 0;
      if (pred >= 0) chk("grant", 64'(m_own), 64'(pred));
      if (prev_owner != 0 && m_own != 0 && m_own != prev_owner) chk("idle_bubble", 64'(m_own), 64'(0));
      if (prev_owner == 2 && m_own == 2) chk("burst_continue", 64'(run_beats < BL && prev_bv), 64'(1));
      if (prev_owner == 2 && m_own != 2) begin
        chk("burst_exit", 64'(run_beats == BL || !prev_bv), 64'(1));
        bursts.push_back(run_beats);
        run_beats = 0;
      end
      chk("blit_ready", 64'(blit_ready), 64'(m_own == 2 && mem_ready));
      if (m_own == 0) chk("idle_mem_valid", 64'(mem_valid), 64'(0));
      if (m_own == 2) begin
        chk("blit_xfer", 64'(s_bx), 64'(mem_valid && mem_ready));
        if (mem_valid && mem_ready) begin
          chk("blit_expected", 64'(exp_bw.size() != 0), 64'(1));
          if (exp_bw.size() != 0) begin
            m_w = exp_bw.pop_front();
            chk("blit_wr", 64'({mem_write, mem_address, mem_byte_en, mem_wdata}), 64'({1'b1, m_w}));
          end
          run_beats++; n_bx++;
        end
      end
      if (m_own == 1 && rd_out) chk("cpu_rd_mem_valid", 64'(mem_valid), 64'(0));
      else if (m_own == 1 && mem_valid && mem_ready) begin
        chk("cpu_expected", 64'(exp_c.size() != 0), 64'(1));
        if (exp_c.size() != 0) begin
          m_c = exp_c[0];
          chk("cpu_req", 64'({mem_write, mem_address, mem_byte_en, m_c.wr ? mem_wdata : 32'd0}),
              64'({m_c.wr, m_c.a, m_c.be, m_c.wr ? m_c.d : 32'd0}));
          chk("cpu_wr_ready", 64'(cpu_ready), 64'(m_c.wr));
          if (!m_c.wr) begin s_racc = 1; s_raddr = mem_address; rd_out = 1; end
        end
      end
      if (prev_rvalid && prev_owner == 1) chk("rd_ready_timing", 64'(cpu_ready), 64'(1));
      if (cpu_ready) begin
        chk("cpu_ready_expected", 64'(exp_c.size() != 0), 64'(1));
        if (exp_c.size() != 0) begin
          m_c = exp_c.pop_front();
          if (!m_c.wr) chk("cpu_rdata", 64'(cpu_rdata), 64'(m_c.rd));
          s_cdone = 1; rd_out = 0;
        end
      end
      // next owner after an idle cycle, from the arbitration rules and the blitter's waiting time
      pred = -1;
      if (m_own == 0) pred = (blit_valid && w_model >= SL) ? 2 : (cpu_valid && !cpu_ready) ? 1 : blit_valid ? 2 : 0;
      if (m_own == 0 && pred == 2) w_model = 0;
      else if (m_own != 2 && blit_valid && w_model < 255) w_model++;
      n_cw += (cpu_valid && m_own != 1) ? 1 : 0;
      if (stat_clr) begin n_bx = 0; n_cw = 0; end
      prev_owner = m_own; prev_rvalid = mem_rvalid; prev_bv = blit_valid;
    end
  end

  initial begin
    int k, t0;
    #1 reset_n = 0;
    #2 chk_zero("reset");
    repeat (2) @(posedge clock);
    #2 reset_n = 1;
    p_rdy = 100;
    cq.push_back('{1'b1, 26'h0000123, 4'hF, 32'hDEADBEEF, 32'd0});
    cq.push_back('{1'b0, RD_A, 4'hF, 32'd0, 32'd0});
    drain(60, "cpu_directed");

    bursts.delete();
    for (int i = 0; i < 40; i++) push_blit();
    drain(300, "burst");
    chk("burst_count", 64'(bursts.size()), 64'(3));
    if (bursts.size() >= 3) begin
      chk("burst0", 64'(bursts[0]), 64'(16));
      chk("burst1", 64'(bursts[1]), 64'(16));
      chk("burst2", 64'(bursts[2]), 64'(8));
    end

    cq.push_back('{1'b1, 26'h0000777, 4'h3, 32'h12345678, 32'd0});
    push_blit();
    k = 0;
    do begin step(); k++; end while (arb_owner == 2'd0 && k < 10);
    chk("priority_first_owner", 64'(arb_owner), 64'(1));
    drain(60, "priority");

    p_cpu = 100; p_rd = 0;
    repeat (4) step();
    t0 = cyc;
    for (int i = 0; i < 4; i++) push_blit();
    k = 0;
    do begin step(); k++; end while (arb_owner != 2'd2 && k < 80);
    chk("starve_grant_by", 64'(cyc - (t0 + 1) <= SL + 2), 64'(1));
    chk("starve_not_early", 64'(cyc - (t0 + 1) >= SL + 1), 64'(1));
    chk("starve_cpu_pending", 64'(cpu_valid), 64'(1));
    p_cpu = 0; p_rd = 50;
    drain(200, "starve");

    stat_clr = 1; step(); stat_clr = 0;
    toggle_rdy = 1;
    for (int i = 0; i < 6; i++) push_blit();
    drain(100, "backpressure");
    toggle_rdy = 0;
`ifdef ARB_STATS_EN
    chk("stat_blit_beats", 64'(stat_blit_beats), 64'(n_bx));
    chk("stat_cpu_wait", 64'(stat_cpu_wait), 64'(n_cw));
`endif

    for (int i = 0; i < 30; i++) push_blit();
    k = 0;
    do begin step(); k++; end while (arb_owner != 2'd2 && k < 10);
    repeat (3) step();
    #1 reset_n = 0;
    #1 chk_zero("reset_blit");
    step();
    #1 reset_n = 1;
    @(negedge clock) chk("reset_release_idle", 64'(arb_owner), 64'(0));
    step();
    @(negedge clock) chk("reset_release_blit", 64'(arb_owner), 64'(2));
    drain(200, "after_reset");

    cq.push_back('{1'b0, 26'h0000abc, 4'hF, 32'd0, 32'd0});
    k = 0;
    do begin step(); k++; end while (arb_owner != 2'd1 && k < 10);
    step();
    chk("rd_outstanding_owner", 64'(arb_owner), 64'(1));
    #1 reset_n = 0;
    exp_c.delete(); cpu_valid = 0;
    step();
    #1 reset_n = 1;
    repeat (8) step();
    chk("stray_rvalid_rdata", 64'(cpu_rdata), 64'(0));
    chk("stray_rvalid_owner", 64'(arb_owner), 64'(0));

    p_cpu = 30; p_blit = 40; p_rd = 50; p_rdy = 70;
    repeat (3000) step();
    p_cpu = 0; p_blit = 0; p_rdy = 100;
    drain(4000, "random");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
